// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
//
// Keeps track of the destination registers of the instructions sitting in the
// EX/MEM and MEM/WB stages. From them it produces the ALU operand bypass
// selects for the instruction currently in EX. It also records any load-use
// dependency that reached EX without a bubble, and counts the bubble cycles
// inserted by the ID stall logic.
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous reset, active-low
//   IDEXRegRs     rs of the instruction in EX
//   IDEXRegRt     rt of the instruction in EX
//   IDEXRegDst    final destination of the instruction in EX
//   IDEXRegWrite  instruction in EX writes the register file
//   IDEXMemRead   instruction in EX is a load
//   hazCtrl       bubble inserted into ID/EX this cycle
//   freeze        whole pipeline holds this cycle
//   flushEX       instruction in EX is killed and must not advance
//   fwdA / fwdB   operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   loadUseErr    sticky flag, load-use dependency reached EX unstalled
//   stallCnt      saturating count of bubble cycles
// -----------------------------------------------------------------------------
module forwarding_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IDEXRegRs,
    input  logic [4:0]       IDEXRegRt,
    input  logic [4:0]       IDEXRegDst,
    input  logic             IDEXRegWrite,
    input  logic             IDEXMemRead,
    input  logic             hazCtrl,
    input  logic             freeze,
    input  logic             flushEX,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             loadUseErr,
    output logic [CNT_W-1:0] stallCnt
);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EM = 2'b10;
    localparam logic [1:0] SEL_MW = 2'b01;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [4:0] em_dst;
    logic       em_wr;
    logic       em_ld;
    logic [4:0] mw_dst;
    logic       mw_wr;

    logic       em_live;
    logic       mw_live;
    logic       load_use_hit;

    // A slot targeting $0 never bypasses, whatever its write bit says.
    assign em_live = em_wr && (em_dst != 5'd0);
    assign mw_live = mw_wr && (mw_dst != 5'd0);

    // em_live already excludes $0, so a match here implies a nonzero source.
    assign load_use_hit = em_live && em_ld &&
                          ((em_dst == IDEXRegRs) || (em_dst == IDEXRegRt));

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwdA = SEL_RF;
        if (em_live && (em_dst == IDEXRegRs)) begin
            fwdA = SEL_EM;
        end else if (mw_live && (mw_dst == IDEXRegRs)) begin
            fwdA = SEL_MW;
        end
    end

    always_comb begin
        fwdB = SEL_RF;
        if (em_live && (em_dst == IDEXRegRt)) begin
            fwdB = SEL_EM;
        end else if (mw_live && (mw_dst == IDEXRegRt)) begin
            fwdB = SEL_MW;
        end
    end

    // Pipeline slots follow the real pipeline: they advance on unfrozen edges,
    // and a flushed EX instruction enters EX/MEM as an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_dst <= 5'd0;
            em_wr  <= 1'b0;
            em_ld  <= 1'b0;
            mw_dst <= 5'd0;
            mw_wr  <= 1'b0;
        end else if (!freeze) begin
            mw_dst <= em_dst;
            mw_wr  <= em_wr;
            if (flushEX) begin
                em_dst <= 5'd0;
                em_wr  <= 1'b0;
                em_ld  <= 1'b0;
            end else begin
                em_dst <= IDEXRegDst;
                em_wr  <= IDEXRegWrite;
                em_ld  <= IDEXMemRead;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loadUseErr <= 1'b0;
        end else if (!freeze && load_use_hit) begin
            loadUseErr <= 1'b1;
        end
    end

    // A bubble still counts when the EX instruction is flushed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (!freeze && hazCtrl && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
module tb_forwarding_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IDEXRegRs, IDEXRegRt, IDEXRegDst;
    logic        IDEXRegWrite, IDEXMemRead, hazCtrl, freeze, flushEX;
    logic [1:0]  fwdA, fwdB, fwdA2, fwdB2;
    logic        loadUseErr, loadUseErr2;
    logic [15:0] stallCnt;
    logic [1:0]  stallCnt2;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    int model_cnt;
    int model_cnt2;

    forwarding_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .IDEXRegRs(IDEXRegRs), .IDEXRegRt(IDEXRegRt), .IDEXRegDst(IDEXRegDst),
        .IDEXRegWrite(IDEXRegWrite), .IDEXMemRead(IDEXMemRead),
        .hazCtrl(hazCtrl), .freeze(freeze), .flushEX(flushEX),
        .fwdA(fwdA), .fwdB(fwdB), .loadUseErr(loadUseErr), .stallCnt(stallCnt)
    );

    forwarding_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .IDEXRegRs(IDEXRegRs), .IDEXRegRt(IDEXRegRt), .IDEXRegDst(IDEXRegDst),
        .IDEXRegWrite(IDEXRegWrite), .IDEXMemRead(IDEXMemRead),
        .hazCtrl(hazCtrl), .freeze(freeze), .flushEX(flushEX),
        .fwdA(fwdA2), .fwdB(fwdB2), .loadUseErr(loadUseErr2), .stallCnt(stallCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic wr, input logic ld,
                          input logic haz, input logic frz, input logic fl);
        IDEXRegRs    = rs;
        IDEXRegRt    = rt;
        IDEXRegDst   = dst;
        IDEXRegWrite = wr;
        IDEXMemRead  = ld;
        hazCtrl      = haz;
        freeze       = frz;
        flushEX      = fl;
    endtask

    // Advances one clock and updates the bench's own counter model from the
    // inputs that were stable at the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n && !freeze && hazCtrl) begin
            if (model_cnt < 65535) model_cnt++;
            if (model_cnt2 < 3) model_cnt2++;
        end
        #1;
    endtask

    task automatic test_power_on();
        rst_n = 1'b0;
        set_in(5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        model_cnt = 0;
        model_cnt2 = 0;
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB, loadUseErr, stallCnt} !== exp_v[20:0]) begin
            failures++;
            $display("FAIL power_on fwdA=%b fwdB=%b err=%b cnt=%0d required all zero",
                     fwdA, fwdB, loadUseErr, stallCnt);
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_chain();
        set_in(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b1000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL alu_chain_em fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
        set_in(5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b0001);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL alu_chain_mw fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
        set_in(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b0000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL alu_chain_rf fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
    endtask

    task automatic test_priority_zero();
        set_in(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b1010);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL priority_em_over_mw fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
        sb_q.push_back(32'b0101);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL priority_mw_only fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b0000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL zero_reg_em fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b0000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL zero_reg_mw fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
    endtask

    task automatic test_flush_freeze();
        set_in(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        set_in(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b0000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL flush_em fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        step();
        sb_q.push_back(32'b0000);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL flush_mw fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        set_in(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        // Freeze with bubble and flush requests that must both be ignored.
        for (int i = 0; i < 3; i++) begin
            set_in(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            sb_q.push_back({model_cnt[15:0], 4'b1000});
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            if ({stallCnt, fwdA, fwdB} !== exp_v[19:0]) begin
                failures++;
                $display("FAIL freeze_hold[%0d] fwdA=%b fwdB=%b cnt=%0d required fwd=%b cnt=%0d",
                         i, fwdA, fwdB, stallCnt, exp_v[3:0], exp_v[19:4]);
            end
            step();
        end
        set_in(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back({16'd0, 4'b1000});
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({stallCnt, fwdA, fwdB} !== exp_v[19:0]) begin
            failures++;
            $display("FAIL freeze_release fwdA=%b fwdB=%b cnt=%0d required fwd=%b cnt=%0d",
                     fwdA, fwdB, stallCnt, exp_v[3:0], exp_v[19:4]);
        end
        step();
        sb_q.push_back(32'b0100);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL freeze_then_mw fwdA=%b fwdB=%b required %b", fwdA, fwdB, exp_v[3:0]);
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_counter();
        for (int i = 0; i < 5; i++) begin
            // Cycle 1 also flushes a producer: the bubble still counts.
            if (i == 1) set_in(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            else        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
            if (i == 1) IDEXRegRs = 5'd6;
            sb_q.push_back({8'd0, 2'(model_cnt2), model_cnt[15:0]});
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            if ({stallCnt2, stallCnt} !== exp_v[17:0]) begin
                failures++;
                $display("FAIL counter[%0d] cnt=%0d cnt_w2=%0d required cnt=%0d cnt_w2=%0d",
                         i, stallCnt, stallCnt2, exp_v[15:0], exp_v[17:16]);
            end
            if (i == 1) begin
                sb_q.push_back(32'b00);
                exp_v = sb_q.pop_front();
                checks++;
                if (fwdA !== exp_v[1:0]) begin
                    failures++;
                    $display("FAIL counter_flush_slot fwdA=%b required %b", fwdA, exp_v[1:0]);
                end
            end
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_load_use();
        set_in(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_in(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(32'b0_10_00);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({loadUseErr, fwdA, fwdB} !== exp_v[4:0]) begin
            failures++;
            $display("FAIL load_use_fwd err=%b fwdA=%b fwdB=%b required %b",
                     loadUseErr, fwdA, fwdB, exp_v[4:0]);
        end
        step();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            sb_q.push_back(32'b1);
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (loadUseErr !== exp_v[0]) begin
                failures++;
                $display("FAIL load_use_sticky[%0d] err=%b required %b", i, loadUseErr, exp_v[0]);
            end
            step();
        end
    endtask

    task automatic test_reset();
        set_in(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_in(5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        #3;
        rst_n = 1'b0;
        model_cnt = 0;
        model_cnt2 = 0;
        sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB, loadUseErr, stallCnt, stallCnt2} !== exp_v[22:0]) begin
            failures++;
            $display("FAIL reset_async fwdA=%b fwdB=%b err=%b cnt=%0d cnt_w2=%0d required all zero",
                     fwdA, fwdB, loadUseErr, stallCnt, stallCnt2);
        end
        #1;
        rst_n = 1'b1;
        sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB} !== exp_v[3:0]) begin
            failures++;
            $display("FAIL reset_release fwdA=%b fwdB=%b required 0000", fwdA, fwdB);
        end
        set_in(5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({fwdA, fwdB, loadUseErr} !== exp_v[4:0]) begin
            failures++;
            $display("FAIL reset_restart_empty fwdA=%b fwdB=%b err=%b required all zero",
                     fwdA, fwdB, loadUseErr);
        end
        step();
    endtask

    initial begin
        test_power_on();
        test_alu_chain();
        test_priority_zero();
        test_flush_freeze();
        test_counter();
        test_load_use();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Tracks in-flight destination registers of the instructions in the EX/MEM and MEM/WB stages of the 5-stage pipeline. Generates the ALU operand forwarding selects for the instruction in EX. Together with the load-use stall logic in ID, it makes up the pipeline's data-hazard handling: ID stalls on load-use, this block bypasses everything else. It also flags any load-use case that reached EX unstalled, and counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- IDEXRegRs  in  5  rs of the instruction in EX
- IDEXRegRt  in  5  rt of the instruction in EX
- IDEXRegDst  in  5  final destination of the instruction in EX (after RegDst mux)
- IDEXRegWrite  in  1  instruction in EX writes the register file
- IDEXMemRead  in  1  instruction in EX is a load
- hazCtrl  in  1  bubble being inserted into ID/EX this cycle (from the ID stall logic)
- freeze  in  1  whole pipeline holds this cycle (memory wait)
- flushEX  in  1  instruction in EX is killed and must not advance
- fwdA  out  2  operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- fwdB  out  2  operand B select, same encoding
- loadUseErr  out  1  sticky: a load-use dependency reached EX without a bubble
- stallCnt  out  CNT_W  saturating count of bubble cycles

## Operation
- Internal slots:
  - EX/MEM slot = {emDst[4:0], emWr, emLd}
  - MEM/WB slot = {mwDst[4:0], mwWr}
  - A slot is "live" when its Wr bit is set and its Dst is not 0.
- Slot update on each rising edge with freeze=0:
  - MEM/WB slot ← EX/MEM slot's {Dst, Wr}.
  - EX/MEM slot ← {IDEXRegDst, IDEXRegWrite, IDEXMemRead}, or all-zero if flushEX=1.
- freeze=1: both slots, loadUseErr and stallCnt hold. flushEX and hazCtrl are ignored that cycle. freeze has priority over flushEX.
- fwdA is combinational on the current slots and IDEXRegRs:
  - 10 if the EX/MEM slot is live and emDst==IDEXRegRs;
  - else 01 if the MEM/WB slot is live and mwDst==IDEXRegRs;
  - else 00.
  - fwdB uses the same rules on IDEXRegRt.
  - EX/MEM always takes priority over MEM/WB.
- Register $0 is never forwarded, even if a slot shows Dst=0 with Wr=1.
- loadUseErr:
  - Set on a rising edge with freeze=0 when the EX/MEM slot is live, emLd=1, and emDst equals a nonzero IDEXRegRs or IDEXRegRt.
  - Cleared only by reset.
  - fwdA/fwdB still report 10 in that case; the data is wrong, and the flag records it.
- stallCnt: increments by 1 on each rising edge with freeze=0 and hazCtrl=1, and saturates at all-ones (no wrap).

## Timing
- Reset (rst_n=0, asynchronous): all slot bits 0, loadUseErr=0, stallCnt=0. With slots empty, fwdA=fwdB=00 during and immediately after reset regardless of inputs.
- Reset deasserted mid-operation: slots restart empty. There is no forwarding from instructions issued before reset.
- fwdA/fwdB have zero-cycle latency from the IDEX* inputs and one-cycle latency from slot capture:
  - a producer in EX at cycle n is forwardable from EX/MEM at cycle n+1;
  - it is forwardable from MEM/WB at cycle n+2;
  - from cycle n+3 the operand comes from the regfile (write-before-read regfile).
- loadUseErr and stallCnt change only on clock edges and are registered outputs.
- hazCtrl=1 with flushEX=1 in the same cycle: the counter still increments, and the slot is cleared.
- The counter at saturation with hazCtrl=1 stays at all-ones.

## Test plan
- Reset: run traffic, then pull rst_n low between edges → fwdA=fwdB=00, loadUseErr=0, stallCnt=0 immediately, before the next edge.
- ALU chain:
  - cycle0: EX Dst=5, Wr=1.
  - cycle1: EX Rs=5 → fwdA=10.
  - cycle2: EX Rt=5 → fwdB=01.
  - cycle3: Rs=5 → fwdA=00.
- Priority and $0:
  - Two consecutive producers both Dst=7, then Rs=Rt=7 → fwdA=fwdB=10.
  - Producer Dst=0, Wr=1, then Rs=0 → fwdA=00.
- Load-use escape: load Dst=3 (MemRead=1, Wr=1) in EX, next cycle Rs=3 with no bubble → fwdA=10, and loadUseErr=1 after that edge. It stays 1 through 10 further clean cycles.
- Flush and freeze:
  - Producer Dst=9 with flushEX=1, next Rs=9 → fwdA=00.
  - Producer Dst=9, then freeze=1 for 3 cycles with Rs=9 → fwdA=10 held throughout, and stallCnt is unchanged even with hazCtrl=1.
- Counter: hazCtrl=1 for 3 unfrozen cycles → stallCnt=3. With CNT_W=2, hold hazCtrl=1 for 5 cycles → stallCnt=3, no wrap.
